z_run_reporter: RTL and testbench

Downstream monitor for the two-input sequence detector's `z` output. Measures every run of consecutive cycles in which `z` is high. Emits one report per completed run through a valid/ready handshake and keeps a saturating count of completed runs. Sits between the detector and the bench/log consumer, so the detector needs no changes.

---
 rtl/z_mon_pkg.sv | 25 ++
 rtl/z_run_reporter_slot.sv | 50 +++++
 rtl/z_run_reporter.sv | 99 +++++++++
 tb/tb_z_run_reporter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z_mon_pkg.sv
// Shared types, default widths and helpers for the z-output run monitor.
package z_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    localparam int DEF_LEN_W = 4;
    localparam int DEF_CNT_W = 8;

    // Increment that sticks at max_value instead of wrapping; callers
    // truncate the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/z_run_reporter_slot.sv
// One-deep valid/ready holding register for a completed-run report.
// A load while full and not draining is refused and flagged on drop.
module rpt_slot #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         drop
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next-state for the slot: a load wins when the slot is empty or draining.
    always_comb begin
        valid_d = valid_q;
        q_d     = q_q;
        if (load && (!valid_q || ready)) begin
            valid_d = 1'b1;
            q_d     = data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot storage with synchronous reset; payload holds while not transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            q_q     <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            q_q     <= q_d;
        end
    end

    assign valid = valid_q;
    assign q     = q_q;
    assign drop  = load && valid_q && !ready;

endmodule

// File: rtl/z_run_reporter.sv
// Measures runs of consecutive high samples of the detector's z output and
// emits one report per completed run, with a saturating completed-run count
// and a sticky overflow flag for reports dropped on a full slot.
module z_run_reporter
    import z_mon_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [LEN_W-1:0] rpt_len,
    output logic             rpt_sat,
    output logic [CNT_W-1:0] run_count,
    output logic             overflow
);

    localparam logic [31:0] LEN_MAX = (32'd1 << LEN_W) - 32'd1;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    run_state_e       state_q;
    logic [LEN_W-1:0] len_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [LEN_W-1:0] len_inc_d;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             complete_s;
    logic             drop_s;
    logic [LEN_W:0]   slot_q_s;

    // Saturating increments of the length counter and completed-run counter.
    always_comb begin
        len_inc_d = LEN_W'(sat_inc(32'(len_q), LEN_MAX));
        cnt_inc_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    end

    // A run completes on the first low sample while in RUN.
    assign complete_s = (state_q == RUN) && !z;

    // Run FSM with length counter, saturation flag, run count and overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= {LEN_W{1'b0}};
            sat_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (z) begin
                        state_q <= RUN;
                        len_q   <= LEN_W'(32'd1);
                        sat_q   <= (LEN_MAX == 32'd1);
                    end
                end
                RUN: begin
                    if (z) begin
                        len_q <= len_inc_d;
                        sat_q <= sat_q || (32'(len_inc_d) == LEN_MAX);
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

    rpt_slot #(
        .W(LEN_W + 1)
    ) u_slot (
        .clk  (clk),
        .rst  (rst),
        .load (complete_s),
        .data ({sat_q, len_q}),
        .ready(rpt_ready),
        .valid(rpt_valid),
        .q    (slot_q_s),
        .drop (drop_s)
    );

    assign rpt_len   = slot_q_s[LEN_W-1:0];
    assign rpt_sat   = slot_q_s[LEN_W];
    assign run_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_z_run_reporter.sv
// Self-checking bench for z_run_reporter: table vectors, directed corner
// sequences and randomized traffic against a run-level reference model.
module tb_z_run_reporter;

    logic       clk;
    logic       rst;
    logic       z;
    logic       rpt_ready;
    logic       rpt_valid;
    logic [3:0] rpt_len;
    logic       rpt_sat;
    logic [7:0] run_count;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, in terms of whole runs.
    bit m_open;
    int m_n;
    bit m_valid;
    int m_len;
    bit m_sat;
    int m_cnt;
    bit m_ovf;

    typedef struct {
        bit r;
        bit zz;
        bit rd;
        bit ev;
        int el;
        bit es;
        int ec;
        bit eo;
    } vec_t;

    vec_t tbl[$];

    z_run_reporter #(.LEN_W(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .z        (z),
        .rpt_ready(rpt_ready),
        .rpt_valid(rpt_valid),
        .rpt_len  (rpt_len),
        .rpt_sat  (rpt_sat),
        .run_count(run_count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given sampled inputs.
    task automatic model_edge(input bit r, input bit zz, input bit rd);
        bit xfer;
        if (r) begin
            m_open = 0; m_n = 0; m_valid = 0; m_len = 0; m_sat = 0;
            m_cnt = 0; m_ovf = 0;
        end else begin
            xfer = m_valid && rd;
            if (m_open && !zz) begin
                if (!m_valid || xfer) begin
                    m_valid = 1;
                    m_len   = (m_n > 15) ? 15 : m_n;
                    m_sat   = (m_n >= 15);
                end else begin
                    m_ovf = 1;
                end
                m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                m_open = 0;
            end else if (xfer) begin
                m_valid = 0;
            end
            if (zz) begin
                if (m_open) m_n = m_n + 1;
                else begin m_open = 1; m_n = 1; end
            end
        end
    endtask

    // Drive one cycle, then compare every output with the model.
    task automatic step(input bit r, input bit zz, input bit rd);
        rst = r; z = zz; rpt_ready = rd;
        @(posedge clk);
        #1;
        model_edge(r, zz, rd);
        chk("model_valid", int'(rpt_valid), int'(m_valid));
        if (m_valid) begin
            chk("model_len", int'(rpt_len), m_len);
            chk("model_sat", int'(rpt_sat), int'(m_sat));
        end
        chk("model_count", int'(run_count), m_cnt);
        chk("model_overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic add(input bit r, input bit zz, input bit rd, input bit ev,
                       input int el, input bit es, input int ec, input bit eo);
        vec_t v;
        v.r = r; v.zz = zz; v.rd = rd; v.ev = ev;
        v.el = el; v.es = es; v.ec = ec; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic run_high(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(0, 1, rd);
    endtask

    initial begin
        bit stable_ok;
        rst = 1'b1; z = 1'b0; rpt_ready = 1'b0;

        // Basic run (ready high): reset twice, z = 0,1,1,0, then idle.
        add(1,0,1, 0,0,0,0,0);
        add(1,0,1, 0,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(0,1,1, 0,0,0,0,0);
        add(0,1,1, 0,0,0,0,0);
        add(0,0,1, 1,2,0,1,0);
        add(0,0,1, 0,0,0,1,0);
        // Backpressure and overflow: z = 1,0,1,1,0 with ready low.
        add(1,0,0, 0,0,0,0,0);
        add(0,1,0, 0,0,0,0,0);
        add(0,0,0, 1,1,0,1,0);
        add(0,1,0, 1,1,0,1,0);
        add(0,1,0, 1,1,0,1,0);
        add(0,0,0, 1,1,0,2,1);
        add(0,0,1, 0,0,0,2,1);
        add(0,0,1, 0,0,0,2,1);
        // Simultaneous consume and load: len 3 held, len 2 completes with ready.
        add(1,0,0, 0,0,0,0,0);
        add(0,1,0, 0,0,0,0,0);
        add(0,1,0, 0,0,0,0,0);
        add(0,1,0, 0,0,0,0,0);
        add(0,0,0, 1,3,0,1,0);
        add(0,1,0, 1,3,0,1,0);
        add(0,1,0, 1,3,0,1,0);
        add(0,0,1, 1,2,0,2,0);
        add(0,0,1, 0,0,0,2,0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].zz, tbl[i].rd);
            chk($sformatf("tbl%0d_valid", i), int'(rpt_valid), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_len", i), int'(rpt_len), tbl[i].el);
                chk($sformatf("tbl%0d_sat", i), int'(rpt_sat), int'(tbl[i].es));
            end
            chk($sformatf("tbl%0d_count", i), int'(run_count), tbl[i].ec);
            chk($sformatf("tbl%0d_overflow", i), int'(overflow), int'(tbl[i].eo));
        end

        // Saturation: 20 highs report max length with sat set.
        do_reset();
        run_high(20, 1);
        step(0, 0, 1);
        chk("sat20_valid", int'(rpt_valid), 1);
        chk("sat20_len", int'(rpt_len), 15);
        chk("sat20_sat", int'(rpt_sat), 1);
        step(0, 0, 1);
        // Exactly max length also flags saturation.
        run_high(15, 1);
        step(0, 0, 1);
        chk("sat15_len", int'(rpt_len), 15);
        chk("sat15_sat", int'(rpt_sat), 1);
        step(0, 0, 1);
        // One below max does not.
        run_high(14, 1);
        step(0, 0, 1);
        chk("sat14_len", int'(rpt_len), 14);
        chk("sat14_sat", int'(rpt_sat), 0);
        step(0, 0, 1);

        // Held report stays stable across several stalled cycles.
        do_reset();
        run_high(6, 0);
        step(0, 0, 0);
        stable_ok = 1;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            if (!(rpt_valid && rpt_len == 4'd6 && !rpt_sat)) stable_ok = 0;
        end
        chk("hold_stable", int'(stable_ok), 1);
        step(0, 0, 1);
        chk("hold_released", int'(rpt_valid), 0);

        // Reset mid-run discards the partial run.
        do_reset();
        run_high(5, 1);
        step(1, 1, 1);
        chk("rstmid_valid", int'(rpt_valid), 0);
        chk("rstmid_count", int'(run_count), 0);
        run_high(2, 1);
        chk("rstmid_open_valid", int'(rpt_valid), 0);
        step(0, 0, 1);
        chk("rstmid_len", int'(rpt_len), 2);
        chk("rstmid_count2", int'(run_count), 1);
        chk("rstmid_rvalid", int'(rpt_valid), 1);

        // Reset with a pending report discards it.
        run_high(3, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("rstpend_valid", int'(rpt_valid), 0);

        // Counter saturation: 300 runs of 1,0.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 1);
            step(0, 0, 1);
        end
        chk("cntsat_count", int'(run_count), 255);
        chk("cntsat_overflow", int'(overflow), 0);
        step(0, 1, 1);
        step(0, 0, 1);
        chk("cntsat_hold", int'(run_count), 255);

        // Randomized traffic with varying run bias and occasional reset.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int bias;
            bias = 30 + blk * 12;
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 399) == 0),
                     ($urandom_range(0, 99) < bias),
                     ($urandom_range(0, 99) < 60));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
